bch63_serial_encoder: RTL and testbench

Serial systematic encoder for the BCH(63,51,t=2) datapath, directly downstream of the 51-bit parallel-to-serial loader. It consumes the MSB-first message bit stream and emits the 63-bit codeword serially: 51 message bits unchanged, then 12 parity bits. Parity is computed by a 12-stage LFSR dividing by g(x) = x^12+x^10+x^8+x^5+x^4+x^3+1 (octal 12471). The assembled codeword is also presented in parallel for the downstream modulator/test harness.

---
 rtl/bch63_serial_encoder.sv | 128 ++++++++++++
 tb/tb_bch63_serial_encoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bch63_serial_encoder.sv
// Serial systematic BCH(63,51,t=2) encoder: passes 51 message bits through, then
// shifts out 12 LFSR parity bits; also assembles the full codeword in parallel.
module bch63_serial_encoder #(
  parameter int unsigned         N     = 63,
  parameter int unsigned         K     = 51,
  parameter logic [N-K-1:0]      GPOLY = 12'h539
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             din,
  output logic             cw_out,
  output logic             cw_valid,
  output logic             busy,
  output logic             done,
  output logic [N-K-1:0]   parity,
  output logic [N-1:0]     codeword
);

  localparam int unsigned PW = N - K;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MSG  = 2'd1,
    S_PAR  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   r_q, r_d;
  logic [PW-1:0]   parity_q, parity_d;
  logic [N-1:0]    codeword_q, codeword_d;
  logic            cw_out_q, cw_out_d;
  logic            cw_valid_q, cw_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fb;

  // Next-state, LFSR and output logic; din is only looked at in S_MSG.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r_d        = r_q;
    parity_d   = parity_q;
    codeword_d = codeword_q;
    cw_out_d   = 1'b0;
    cw_valid_d = 1'b0;
    done_d     = 1'b0;
    fb         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_MSG;
          cnt_d      = '0;
          r_d        = '0;
          parity_d   = '0;
          codeword_d = '0;
        end
      end
      S_MSG: begin
        fb         = din ^ r_q[PW-1];
        r_d        = {r_q[PW-2:0], 1'b0} ^ (fb ? GPOLY : PW'(0));
        cw_out_d   = din;
        cw_valid_d = 1'b1;
        codeword_d = {codeword_q[N-2:0], din};
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) begin
          state_d  = S_PAR;
          cnt_d    = '0;
          // Remainder is final once the last message bit is folded in.
          parity_d = r_d;
        end
      end
      S_PAR: begin
        r_d        = {r_q[PW-2:0], 1'b0};
        cw_out_d   = r_q[PW-1];
        cw_valid_d = 1'b1;
        codeword_d = {codeword_q[N-2:0], r_q[PW-1]};
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(PW - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      r_q        <= '0;
      parity_q   <= '0;
      codeword_q <= '0;
      cw_out_q   <= 1'b0;
      cw_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      parity_q   <= parity_d;
      codeword_q <= codeword_d;
      cw_out_q   <= cw_out_d;
      cw_valid_q <= cw_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign cw_out   = cw_out_q;
  assign cw_valid = cw_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign parity   = parity_q;
  assign codeword = codeword_q;

endmodule

// File: tb/tb_bch63_serial_encoder.sv
// Directed bench for bch63_serial_encoder: frame timing, parity values, serial/parallel
// codeword agreement, start-while-busy, back-to-back frames and mid-frame reset.
module tb_bch63_serial_encoder;

  localparam int unsigned K = 51;

  logic        clk = 1'b0;
  logic        reset, start, din;
  logic        cw_out, cw_valid, busy, done;
  logic [11:0] parity;
  logic [62:0] codeword;

  int checks = 0;
  int errors = 0;

  logic [64:0] rec_valid, rec_busy, rec_done;
  logic [64:0] exp_valid, exp_busy, exp_done;
  logic [62:0] rec_ser, rec_cw;
  logic [11:0] rec_par;

  always #5 clk = ~clk;

  bch63_serial_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .din      (din),
    .cw_out   (cw_out),
    .cw_valid (cw_valid),
    .busy     (busy),
    .done     (done),
    .parity   (parity),
    .codeword (codeword)
  );

  // Reference remainder by long division of m(x)*x^12 by g(x) = 0x1539.
  function automatic logic [11:0] ref_parity(input logic [50:0] msg);
    logic [62:0] rem;
    rem = {msg, 12'h000};
    for (int i = 62; i >= 12; i--)
      if (rem[i]) rem[i -: 13] = rem[i -: 13] ^ 13'h1539;
    return rem[11:0];
  endfunction

  // Called at a negedge of cycle n: pulses start, feeds the message, records cycles n+1..n+stop_at.
  task automatic drive_frame(input logic [50:0] msg, input int stop_at, input int extra_start);
    rec_valid = '0; rec_busy = '0; rec_done = '0;
    rec_ser = '0; rec_cw = '0; rec_par = '0;
    start = 1'b1;
    din   = 1'bx;
    for (int k = 1; k <= stop_at; k++) begin
      @(negedge clk);
      rec_valid[k] = cw_valid;
      rec_busy[k]  = busy;
      rec_done[k]  = done;
      if (k >= 2 && k <= 64) rec_ser = {rec_ser[61:0], cw_out};
      if (k == 64) begin
        rec_cw  = codeword;
        rec_par = parity;
      end
      start = (k == extra_start);
      din   = (k <= int'(K)) ? msg[int'(K) - k] : 1'bx;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; din = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cw_out, cw_valid, busy, done, parity, codeword} !== 79'd0) begin
      errors++;
      $display("FAIL reset_outputs: got cw_out=%b valid=%b busy=%b done=%b parity=%h cw=%h, want all 0",
               cw_out, cw_valid, busy, done, parity, codeword);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 100; c++) begin
      din = 1'($urandom_range(1));
      @(negedge clk);
      checks++;
      if ({cw_out, cw_valid, busy, done, parity, codeword} !== 79'd0) begin
        errors++;
        $display("FAIL idle_cycle%0d: got valid=%b busy=%b done=%b parity=%h cw=%h, want all 0",
                 c, cw_valid, busy, done, parity, codeword);
      end
    end
  endtask

  task automatic test_zero_msg();
    drive_frame(51'd0, 64, 0);
    checks++;
    if (rec_busy !== exp_busy) begin
      errors++; $display("FAIL zero_busy_profile: got %h, want %h", rec_busy, exp_busy);
    end
    checks++;
    if (rec_valid !== exp_valid) begin
      errors++; $display("FAIL zero_valid_profile: got %h, want %h", rec_valid, exp_valid);
    end
    checks++;
    if (rec_done !== exp_done) begin
      errors++; $display("FAIL zero_done_profile: got %h, want %h", rec_done, exp_done);
    end
    checks++;
    if (rec_par !== 12'h000 || rec_cw !== 63'd0 || rec_ser !== 63'd0) begin
      errors++; $display("FAIL zero_codeword: got parity=%h cw=%h ser=%h, want all 0", rec_par, rec_cw, rec_ser);
    end
    @(negedge clk);
    checks++;
    if (cw_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_after_done: got valid=%b done=%b busy=%b, want 0 0 0", cw_valid, done, busy);
    end
  endtask

  task automatic test_unit_msgs();
    logic [50:0] msgs [3];
    logic [11:0] pars [3];
    logic [62:0] exp_cw;
    msgs = '{51'd1, 51'd2, 51'd3};
    pars = '{12'h539, 12'hA72, 12'hF4B};
    for (int i = 0; i < 3; i++) begin
      drive_frame(msgs[i], 64, 0);
      exp_cw = {msgs[i], pars[i]};
      checks++;
      if (rec_par !== pars[i]) begin
        errors++; $display("FAIL unit%0d_parity: got %h, want %h", i + 1, rec_par, pars[i]);
      end
      checks++;
      if (rec_cw !== exp_cw) begin
        errors++; $display("FAIL unit%0d_codeword: got %h, want %h", i + 1, rec_cw, exp_cw);
      end
      checks++;
      if (rec_ser !== exp_cw) begin
        errors++; $display("FAIL unit%0d_serial: got %h, want %h", i + 1, rec_ser, exp_cw);
      end
      @(negedge clk);
      checks++;
      if (codeword !== exp_cw || cw_valid !== 1'b0) begin
        errors++; $display("FAIL unit%0d_hold: got cw=%h valid=%b, want %h 0", i + 1, codeword, cw_valid, exp_cw);
      end
    end
  endtask

  task automatic test_random();
    logic [50:0] msg;
    logic [11:0] p;
    for (int i = 0; i < 200; i++) begin
      msg = 51'({$urandom(), $urandom()});
      p   = ref_parity(msg);
      drive_frame(msg, 64, 0);
      checks++;
      if (rec_par !== p || rec_cw !== {msg, p} || rec_ser !== {msg, p} || rec_done !== exp_done) begin
        errors++;
        $display("FAIL random%0d: got parity=%h cw=%h ser=%h done=%h, want parity=%h cw=%h done=%h",
                 i, rec_par, rec_cw, rec_ser, rec_done, p, {msg, p}, exp_done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_while_busy();
    logic [50:0] msg;
    logic [11:0] p;
    msg = 51'h5_A5A5_C3C3_0F0F;
    p   = ref_parity(msg);
    drive_frame(msg, 64, 20);
    checks++;
    if (rec_done !== exp_done || rec_busy !== exp_busy || rec_valid !== exp_valid) begin
      errors++; $display("FAIL busy_start_timing: got done=%h busy=%h, want done=%h busy=%h",
                         rec_done, rec_busy, exp_done, exp_busy);
    end
    checks++;
    if (rec_cw !== {msg, p} || rec_par !== p) begin
      errors++; $display("FAIL busy_start_codeword: got %h parity=%h, want %h parity=%h", rec_cw, rec_par, {msg, p}, p);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [50:0] ma, mb;
    ma = 51'h7_FFFF_FFFF_FFFF;
    mb = 51'h1_2345_6789_ABCD;
    drive_frame(ma, 64, 0);
    checks++;
    if (rec_cw !== {ma, ref_parity(ma)} || rec_done !== exp_done) begin
      errors++; $display("FAIL b2b_first: got %h done=%h, want %h", rec_cw, rec_done, {ma, ref_parity(ma)});
    end
    drive_frame(mb, 64, 0);
    checks++;
    if (rec_cw !== {mb, ref_parity(mb)} || rec_ser !== {mb, ref_parity(mb)}) begin
      errors++; $display("FAIL b2b_second: got cw=%h ser=%h, want %h", rec_cw, rec_ser, {mb, ref_parity(mb)});
    end
    checks++;
    if (rec_busy !== exp_busy || rec_valid !== exp_valid || rec_done !== exp_done) begin
      errors++; $display("FAIL b2b_second_timing: got busy=%h valid=%h done=%h, want %h %h %h",
                         rec_busy, rec_valid, rec_done, exp_busy, exp_valid, exp_done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_par();
    logic [50:0] msg;
    msg = 51'h2_AAAA_5555_F00D;
    drive_frame(msg, 56, 0);
    checks++;
    if (busy !== 1'b1 || cw_valid !== 1'b1) begin
      errors++; $display("FAIL midpar_precheck: got busy=%b valid=%b, want 1 1", busy, cw_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({cw_out, cw_valid, busy, done, parity, codeword} !== 79'd0) begin
      errors++; $display("FAIL midpar_reset: got valid=%b busy=%b done=%b parity=%h cw=%h, want all 0",
                         cw_valid, busy, done, parity, codeword);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cw_valid !== 1'b0) begin
      errors++; $display("FAIL midpar_idle: got busy=%b valid=%b, want 0 0", busy, cw_valid);
    end
    msg = 51'h0_0F0F_F0F0_1234;
    drive_frame(msg, 64, 0);
    checks++;
    if (rec_cw !== {msg, ref_parity(msg)} || rec_done !== exp_done || rec_par !== ref_parity(msg)) begin
      errors++; $display("FAIL midpar_next_frame: got %h done=%h, want %h", rec_cw, rec_done, {msg, ref_parity(msg)});
    end
    @(negedge clk);
  endtask

  initial begin
    exp_busy = '0; exp_valid = '0; exp_done = '0;
    for (int k = 1; k <= 63; k++) exp_busy[k] = 1'b1;
    for (int k = 2; k <= 64; k++) exp_valid[k] = 1'b1;
    exp_done[64] = 1'b1;

    test_reset();
    test_idle();
    test_zero_msg();
    test_unit_msgs();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_par();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
